// File: rtl/wptr_full.sv
// Write-side pointer and flag logic for a dual-clock FIFO. It keeps binary and Gray write
// pointers, generates the memory write strobe, and derives the full, level and overflow flags.
module wptr_full #(
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   localparam int ADDR     = $clog2(DEPTH)
) (
   input  logic            w_clk,
   input  logic            rst_n,
   input  logic            w_inc,
   input  logic [ADDR:0]   wq2_rptr,
   input  logic            w_ovf_clr,
   output logic            w_en,
   output logic [ADDR-1:0] w_addr,
   output logic [ADDR:0]   wptr,
   output logic            w_full,
   output logic            w_almost_full,
   output logic [ADDR:0]   w_level,
   output logic            w_overflow
);

   localparam logic [ADDR:0] AF_LEVEL = (ADDR+1)'(AF_THRESH);

   logic [ADDR:0] wbin;
   logic [ADDR:0] wbin_next;
   logic [ADDR:0] wgray_next;
   logic [ADDR:0] rbin_sync;
   logic [ADDR:0] level_next;
   logic [ADDR:0] full_ptr;

   // The write strobe is gated only by the registered full flag, so wq2_rptr never reaches an output combinationally.
   assign w_en       = w_inc & ~w_full;
   assign w_addr     = wbin[ADDR-1:0];
   assign wbin_next  = wbin + (ADDR+1)'(w_en);
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // The FIFO is full when the write pointer is one lap ahead of the read pointer. In Gray code
   // that is the read pointer with its top two bits inverted.
   assign full_ptr = {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]};

   genvar gi;
   generate
      for (gi = 0; gi <= ADDR; gi++) begin : g_gray2bin
         assign rbin_sync[gi] = ^wq2_rptr[ADDR:gi];
      end
   endgenerate

   assign level_next = wbin_next - rbin_sync;

   always_ff @(posedge w_clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin          <= '0;
         wptr          <= '0;
         w_full        <= 1'b0;
         w_almost_full <= 1'b0;
         w_level       <= '0;
         w_overflow    <= 1'b0;
      end else begin
         wbin          <= wbin_next;
         wptr          <= wgray_next;
         w_full        <= (wgray_next == full_ptr);
         w_almost_full <= (level_next >= AF_LEVEL);
         w_level       <= level_next;
         // A rejected write sets the flag and wins over a clear that arrives in the same cycle.
         if (w_inc && w_full)
            w_overflow <= 1'b1;
         else if (w_ovf_clr)
            w_overflow <= 1'b0;
      end
   end

endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and flag generator for the dual-clock FIFO.
- Keeps the binary and Gray write pointers and issues the memory write enable and address.
- Compares the next write pointer against the Gray read pointer already synchronised into w_clk, producing full, almost-full, fill level and a sticky overflow flag.
- The Gray write pointer wptr goes to the two-flop synchroniser that feeds the read domain.

Parameters:
- DEPTH, 8, FIFO entries. Power of two, >= 4. ADDR = $clog2(DEPTH); pointers are ADDR+1 bits.
- AF_THRESH, DEPTH-2, fill level at or above which w_almost_full asserts. Range 1..DEPTH.

Ports:
- w_clk  input  1  write-domain clock.
- rst_n  input  1  asynchronous, active-low reset.
- w_inc  input  1  write request for the current cycle.
- wq2_rptr  input  ADDR+1  Gray read pointer, already synchronised to w_clk.
- w_ovf_clr  input  1  synchronous clear of w_overflow.
- w_en  output  1  memory write enable, equal to w_inc & ~w_full (combinational).
- w_addr  output  ADDR  memory write address, equal to wbin[ADDR-1:0].
- wptr  output  ADDR+1  registered Gray write pointer, sent toward the read domain.
- w_full  output  1  registered full flag.
- w_almost_full  output  1  registered, asserted when level >= AF_THRESH.
- w_level  output  ADDR+1  registered fill level, 0..DEPTH.
- w_overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (async assert, sync deassert from w_clk's view): wbin, wptr and w_level are 0. w_full, w_almost_full and w_overflow are 0. w_en follows w_inc, because w_full is 0.
- Next-state values:
  - wbin_next = wbin + (w_inc & ~w_full), modulo 2^(ADDR+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every w_clk edge registers wbin <= wbin_next and wptr <= wgray_next. wptr changes at most one bit per edge, which is mandatory for the CDC path.
- Full:
  - w_full <= (wgray_next == {~wq2_rptr[ADDR:ADDR-1], wq2_rptr[ADDR-2:0]}).
  - w_full therefore asserts on the same edge that accepts the DEPTH-th outstanding write.
  - It is re-evaluated every cycle, so it deasserts on the first edge after wq2_rptr advances, even with no write.
- Level:
  - rbin_sync = Gray-to-binary(wq2_rptr), computed combinationally as an XOR prefix from the MSB.
  - w_level <= (wbin_next - rbin_sync) mod 2^(ADDR+1). The result never exceeds DEPTH.
  - w_almost_full <= (level_next >= AF_THRESH).
- Level and flags are pessimistic. wq2_rptr lags the true read pointer by 2-3 w_clk cycles, so the level may overstate occupancy but never understates it.
- Write while full: no pointer change and w_en = 0; w_overflow <= 1 on that edge.
  - If w_ovf_clr and an overflow attempt occur in the same cycle, set wins.
  - Otherwise w_ovf_clr drives w_overflow to 0 on the next edge.
- Wrap-around: wbin rolls from 2^(ADDR+1)-1 to 0 with no special handling. The extra MSB distinguishes full from empty.
- Simultaneous write and read-pointer advance when full: w_full is 1 in that cycle, so the write is rejected and flagged as overflow. w_full clears on the next edge.
- Reset mid-operation: all state returns immediately to reset values. The reader side is reset by the same rst_n; no handshake is required.
- No combinational path from wq2_rptr to any output except through registers. w_en depends only on w_inc and the registered w_full.

Test Plan (DEPTH=8, AF_THRESH=6 unless stated):
- Reset, then 8 consecutive w_inc with wq2_rptr=0 -> wptr sequence 1,3,2,6,7,5,4,12. w_full=1 after the 8th edge. w_level=8. w_almost_full=1 after the 6th edge. w_addr cycles 0..7.
- While full, w_inc=1 for 2 cycles -> w_en=0, wptr stays 12, w_overflow=1 and remains set. Then w_ovf_clr pulse -> w_overflow=0 next edge.
- Full state, wq2_rptr set to 3 (binary 2) -> w_full=0 and w_level=6 on the next edge with no write. One write -> w_level=7, w_full=0.
- Wrap: 40 writes with the model reader keeping wq2_rptr 2 entries behind -> wbin wraps past 15 to 0, every wptr step is a single-bit change, w_full never asserts, and w_level stays at 2-3.
- AF_THRESH=8: fill to 7 -> w_almost_full=0. 8th write -> w_almost_full and w_full both 1 on the same edge.
- Assert rst_n=0 mid-fill at level 5 -> outputs return to 0 asynchronously before the next clock edge. After release, the first write produces wptr=1.
